// File: rtl/e4m3_mul_arbiter.sv
// e4m3_mul_arbiter: round-robin arbiter that shares one external e4m3
// multiplier among four requesters, with one operation in flight at a time.
// Optional WAIT watchdog enabled by defining E4M3_MUL_ARB_TIMEOUT_EN.
module e4m3_mul_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_y,
    output logic [1:0]  resp_id,
    output logic        resp_err,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_reset,
    input  logic [7:0]  mul_y,
    input  logic        mul_valid
);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

    state_e     state_q, state_d;
    logic [1:0] last_grant_q;
    logic [1:0] grant_idx;
    logic       grant_any;
    logic       load_op;
    logic       take_y;
    logic [7:0] op_a_q, op_b_q;
    logic [7:0] y_q;
    logic [1:0] id_q;

`ifdef E4M3_MUL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;
    logic            timeout;
    logic            err_q;
`endif

    // Round-robin search from last_grant+1; nearest valid requester wins.
    always_comb begin
        logic [1:0] idx;
        idx       = last_grant_q;
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        for (int i = 4; i >= 1; i--) begin
            idx = last_grant_q + 2'(i);
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Next-state and grant strobe.
    always_comb begin
        state_d   = state_q;
        req_ready = 4'b0000;
        load_op   = 1'b0;
        take_y    = 1'b0;
`ifdef E4M3_MUL_ARB_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_any && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    load_op              = 1'b1;
                    state_d              = StLoad;
                end
            end
            StLoad: state_d = StWait;
            StWait: begin
                if (mul_valid) begin
                    take_y  = 1'b1;
                    state_d = StResp;
                end
`ifdef E4M3_MUL_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_d = StResp;
                end
`endif
            end
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, grant history, operand and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 2'd3;
            op_a_q       <= 8'h00;
            op_b_q       <= 8'h00;
            y_q          <= 8'h00;
            id_q         <= 2'd0;
        end else begin
            state_q <= state_d;
            if (load_op) begin
                last_grant_q <= grant_idx;
                id_q         <= grant_idx;
                op_a_q       <= req_a[{grant_idx, 3'b000} +: 8];
                op_b_q       <= req_b[{grant_idx, 3'b000} +: 8];
            end
            if (take_y) y_q <= mul_y;
`ifdef E4M3_MUL_ARB_TIMEOUT_EN
            else if (timeout) y_q <= 8'h7F;
`endif
        end
    end

`ifdef E4M3_MUL_ARB_TIMEOUT_EN
    // Watchdog: cleared while in LOAD so it starts at zero on WAIT entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StLoad) cnt_q <= '0;
            else if (state_q == StWait) cnt_q <= cnt_q + 1'b1;
            if (take_y) err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_valid = (state_q == StResp);
    assign resp_y     = y_q;
    assign resp_id    = id_q;
    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;
    assign mul_reset  = reset | (state_q == StLoad);

endmodule

// File: tb/tb_e4m3_mul_arbiter.sv
// Directed bench for e4m3_mul_arbiter with a fixed-latency multiplier stub.
module tb_e4m3_mul_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_y;
    logic [1:0]  resp_id;
    logic        resp_err;
    logic [7:0]  mul_a, mul_b;
    logic        mul_reset;
    logic [7:0]  mul_y;
    logic        mul_valid;

    int checks = 0;
    int failures = 0;

    // Multiplier stub controls
    logic       stale  = 1'b0;
    logic       stuck0 = 1'b0;
    logic [1:0] m_cnt  = '0;
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_y    = 8'h00;
    localparam int LAT = 2;

    always #5 clock = ~clock;

    e4m3_mul_arbiter #(.TIMEOUT_CYCLES(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_reset  (mul_reset),
        .mul_y      (mul_y),
        .mul_valid  (mul_valid)
    );

    // Hand-computed e4m3 products for the operand pairs used here
    function automatic logic [7:0] prod(input logic [7:0] a, input logic [7:0] b);
        case ({a, b})
            16'h4040: prod = 8'h48;
            16'h3838: prod = 8'h38;
            16'h38B8: prod = 8'hB8;
            16'h4039: prod = 8'h41;
            16'hACC0: prod = 8'h34;
            default:  prod = 8'h00;
        endcase
    endfunction

    always @(posedge clock) begin
        if (mul_reset) begin
            m_cnt   <= '0;
            m_busy  <= 1'b1;
            m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 2'(LAT - 1)) begin
                m_valid <= 1'b1;
                m_y     <= prod(mul_a, mul_b);
                m_busy  <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1'b1;
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

    assign mul_valid = (m_valid & ~stuck0) | stale;
    assign mul_y     = stale ? 8'hEE : m_y;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("resp_arrives", {31'b0, resp_valid}, 32'd1);
    endtask

    logic [7:0] exp_y [4] = '{8'h38, 8'hB8, 8'h41, 8'h34};

    initial begin
        int n;
        // Reset state, with requests present to show req_ready stays low
        reset     = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_y", {24'b0, resp_y}, 32'h00);
        chk("rst_resp_id", {30'b0, resp_id}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
        chk("rst_mul_a", {24'b0, mul_a}, 32'h00);
        chk("rst_mul_b", {24'b0, mul_b}, 32'h00);
        chk("rst_mul_reset", {31'b0, mul_reset}, 32'd1);
        req_valid = 4'h0;
        reset     = 1'b0;
        tick();

        // Single requester 0: 2.0 * 2.0 = 4.0
        req_a = 32'h0000_0040;
        req_b = 32'h0000_0040;
        req_valid = 4'b0001;
        #1;
        chk("s1_grant", {28'b0, req_ready}, 32'b0001);
        tick();
        chk("s1_ready_drop", {28'b0, req_ready}, 32'd0);
        chk("s1_load_mulreset", {31'b0, mul_reset}, 32'd1);
        chk("s1_mul_a", {24'b0, mul_a}, 32'h40);
        chk("s1_mul_b", {24'b0, mul_b}, 32'h40);
        req_valid = 4'b0000;
        tick();
        chk("s1_wait_mulreset", {31'b0, mul_reset}, 32'd0);
        wait_resp(n);
        chk("s1_y", {24'b0, resp_y}, 32'h48);
        chk("s1_id", {30'b0, resp_id}, 32'd0);
        chk("s1_err", {31'b0, resp_err}, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("s1_idle_after_hs", {31'b0, resp_valid}, 32'd0);

        // All four requesters continuously valid: order 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = {8'hAC, 8'h40, 8'h38, 8'h38};
        req_b = {8'hC0, 8'h39, 8'hB8, 8'h38};
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_resp(n);
            chk("rr_id", {30'b0, resp_id}, 32'(k % 4));
            chk("rr_y", {24'b0, resp_y}, {24'b0, exp_y[k % 4]});
            chk("rr_err", {31'b0, resp_err}, 32'd0);
            tick();
        end

        // Consumer stall in RESP: next owner is requester 1
        resp_ready = 1'b0;
        wait_resp(n);
        chk("st_id", {30'b0, resp_id}, 32'd1);
        chk("st_y", {24'b0, resp_y}, 32'hB8);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("st_valid_hold", {31'b0, resp_valid}, 32'd1);
            chk("st_y_hold", {24'b0, resp_y}, 32'hB8);
            chk("st_id_hold", {30'b0, resp_id}, 32'd1);
            chk("st_no_ready", {28'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("st_regrant", {28'b0, req_ready}, 32'b0100);
        tick();
        req_valid = 4'h0;
        wait_resp(n);
        chk("st_next_id", {30'b0, resp_id}, 32'd2);
        chk("st_next_y", {24'b0, resp_y}, 32'h41);
        tick();

        // Reset in WAIT discards the in-flight result
        req_a = 32'h0000_4040;
        req_b = 32'h0000_4040;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        chk("rw_in_wait", {31'b0, mul_reset}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rw_mulreset_comb", {31'b0, mul_reset}, 32'd1);
        tick();
        chk("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rw_mulreset", {31'b0, mul_reset}, 32'd1);
        chk("rw_mul_a", {24'b0, mul_a}, 32'h00);
        reset = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("rw_req0_first", {28'b0, req_ready}, 32'b0001);
        req_valid = 4'b0010;
        #1;
        chk("rw_req1_alone", {28'b0, req_ready}, 32'b0010);
        tick();
        req_valid = 4'b0000;
        wait_resp(n);
        chk("rw_id", {30'b0, resp_id}, 32'd1);
        chk("rw_y", {24'b0, resp_y}, 32'h48);
        tick();

        // Stale mul_valid during LOAD must be ignored
        req_a = 32'h0000_0040;
        req_b = 32'h0000_0039;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        chk("stale_in_load", {31'b0, mul_reset}, 32'd1);
        stale = 1'b1;
        tick();
        stale = 1'b0;
        wait_resp(n);
        chk("stale_y", {24'b0, resp_y}, 32'h41);
        chk("stale_id", {30'b0, resp_id}, 32'd0);
        tick();

        // Multiplier never responds
        stuck0 = 1'b1;
        req_a = 32'h0000_0040;
        req_b = 32'h0000_0040;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
`ifdef E4M3_MUL_ARB_TIMEOUT_EN
        wait_resp(n);
        chk("to_wait_cycles", n, 32'd33);
        chk("to_y", {24'b0, resp_y}, 32'h7F);
        chk("to_err", {31'b0, resp_err}, 32'd1);
        tick();
        stuck0 = 1'b0;
`else
        for (int k = 0; k < 50; k++) tick();
        chk("nto_still_waiting", {31'b0, resp_valid}, 32'd0);
        chk("nto_err", {31'b0, resp_err}, 32'd0);
        stuck0 = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        tick();
        chk("nto_recovered", {31'b0, resp_valid}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/e4m3_mul_arbiter.md
E4M3_MUL_ARBITER -- requirements
Module: e4m3_mul_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 32, the watchdog limit in WAIT (used only with the Configuration macro).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have the following ports, one per line:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- req_valid  input  4  per-requester operation request
- req_a  input  32  packed operand A, requester i at bits [8i+7:8i], e4m3
- req_b  input  32  packed operand B, same packing
- req_ready  output  4  one-hot accept strobe, combinational
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_y  output  8  e4m3 product
- resp_id  output  2  index of the requester that owns resp_y
- resp_err  output  1  watchdog expired for this result
- mul_a  output  8  operand A to the shared multiplier
- mul_b  output  8  operand B to the shared multiplier
- mul_reset  output  1  multiplier start/clear pulse
- mul_y  input  8  multiplier result
- mul_valid  input  1  multiplier output-valid flag

Function
REQ-004 The block SHALL share one external e4m3 multiplier among 4 requesters, one operation in flight at a time.
REQ-005 The FSM SHALL have the states IDLE, LOAD, WAIT and RESP.
REQ-006 In IDLE with any req_valid high, the block SHALL grant exactly one requester g by round-robin, searching from last_grant+1 mod 4.
REQ-007 In the grant cycle, req_ready[g] SHALL be 1 for that cycle only; the block SHALL register req_a[g], req_b[g] and g, then go to LOAD.
REQ-008 req_ready SHALL be 0 in LOAD, WAIT and RESP, and in IDLE when no req_valid is high.
REQ-009 mul_a and mul_b SHALL be driven from the operand registers and held stable from LOAD until the FSM returns to IDLE.
REQ-010 In LOAD, mul_reset SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-011 mul_reset SHALL be 0 in WAIT and RESP.
REQ-012 In WAIT, when mul_valid is 1, the block SHALL register mul_y into resp_y and go to RESP.
REQ-013 mul_valid SHALL be ignored outside WAIT, including stale highs during LOAD.
REQ-014 In RESP, resp_valid SHALL be 1 and resp_y, resp_id and resp_err SHALL be stable; on resp_valid&&resp_ready the FSM SHALL go to IDLE.
REQ-015 A new grant SHALL be possible in the first IDLE cycle after the response handshake; no bypass from RESP to LOAD.
REQ-016 last_grant SHALL update only on a grant.
REQ-017 If a requester drops req_valid before it is granted, it SHALL lose its turn silently.
REQ-018 Latency from grant to resp_valid SHALL be L+2 cycles, where L is the number of multiplier cycles from mul_reset deassertion to mul_valid.

Reset
REQ-019 reset SHALL, synchronously and regardless of state (including mid-operation), force state to IDLE and last_grant to 3 (requester 0 first).
REQ-020 reset SHALL force resp_valid=0, resp_y=0, resp_id=0, resp_err=0, req_ready=0, mul_a=0, mul_b=0 and the watchdog count to 0.
REQ-021 mul_reset SHALL be 1 while reset is 1.
REQ-022 An in-flight result SHALL be discarded on reset.

Configuration
REQ-023 The macro E4M3_MUL_ARB_TIMEOUT_EN SHALL control the WAIT watchdog.
REQ-024 With the macro defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-025 With the macro defined, if TIMEOUT_CYCLES WAIT cycles pass without mul_valid, the block SHALL load resp_y=8'h7F (NaN), set resp_err=1 and go to RESP.
REQ-026 With the macro defined, resp_err SHALL be 0 for normal completions.
REQ-027 Without the macro, there SHALL be no counter, WAIT SHALL persist until mul_valid, and resp_err SHALL be constant 0.

Verification
REQ-028 With the real multiplier attached, the bench SHALL cover these directed scenarios:
- Requester 0 only, a=0x40, b=0x40 -> resp_y=0x48, resp_id=0, resp_err=0, req_ready[0] pulses one cycle.
- All 4 requesters valid continuously with operand pairs (0x38,0x38), (0x38,0xB8), (0x40,0x39), (0xAC,0xC0) -> responses in order id 0,1,2,3 with results 0x38, 0xB8, 0x41, 0x34; then id 0 again.
- resp_ready held 0 for 10 cycles in RESP -> resp_valid, resp_y and resp_id stay stable; no req_ready pulses until the handshake.
- Reset asserted during WAIT -> next cycle IDLE, resp_valid=0, mul_reset=1; a subsequent request from requester 1 is granted before requester 0 only if requester 0 is idle.
- With E4M3_MUL_ARB_TIMEOUT_EN and mul_valid stuck 0 (stub multiplier) -> resp_valid after 32 WAIT cycles with resp_y=0x7F and resp_err=1.
- Stale mul_valid=1 during LOAD -> ignored; resp_y equals the true product.
